// File: rtl/count_sequence_checker_pkg.sv
// Shared definitions for the count sequence checker: the FSM state encoding
// and the default values of the checker parameters.
package count_sequence_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } state_e;

  localparam int DEFAULT_LOCK_LEN = 4;
  localparam int DEFAULT_ERR_W    = 8;

endpackage

// File: rtl/count_sequence_checker_sat_counter.sv
// Saturating up-counter: counts enabled increments and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Increment on request unless already at all-ones; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Checks that accepted samples of a free-running 2-bit counter advance by
// exactly one (mod 4), tracks lock over LOCK_LEN consecutive correct steps,
// and counts sequence errors. All outputs are registered (1-cycle latency).
//
// Handshake: count is a sample only in a cycle where count_valid is high at
// the rising clock edge and rst is low; there is no back-pressure, every
// such sample is consumed in that cycle.
module count_sequence_checker
  import count_sequence_checker_pkg::*;
#(
  parameter int LOCK_LEN = DEFAULT_LOCK_LEN,  // legal range 1..15
  parameter int ERR_W    = DEFAULT_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       count,
  input  logic             count_valid,
  output logic [3:0]       phase,
  output logic             wrap,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [3:0] LOCK_LEN_C = 4'(LOCK_LEN);

  state_e     state_q;
  logic [1:0] prev_q;
  logic [3:0] run_q;
  logic [3:0] phase_q;
  logic       wrap_q;
  logic       seq_err_q;

  logic [1:0] expected_d;
  logic       correct_d;
  logic       err_inc_d;
  logic [3:0] run_inc_d;

  // Compare the incoming sample with the successor of the last accepted one.
  // No check is made before a previous sample exists (IDLE).
  always_comb begin
    expected_d = prev_q + 2'd1;
    correct_d  = (count == expected_d);
    err_inc_d  = count_valid && (state_q != IDLE) && !correct_d;
    run_inc_d  = run_q + 4'd1;
  end

  // Lock FSM, previous-sample register and registered pulse/decode outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_q    <= 2'd0;
      run_q     <= 4'd0;
      phase_q   <= 4'b0000;
      wrap_q    <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      wrap_q    <= count_valid && (state_q != IDLE) && correct_d && (prev_q == 2'd3);
      seq_err_q <= err_inc_d;
      if (count_valid) begin
        // Every accepted sample becomes the reference, right or wrong.
        prev_q  <= count;
        phase_q <= 4'b0001 << count;
        case (state_q)
          IDLE: begin
            state_q <= TRACK;
            run_q   <= 4'd0;
          end
          TRACK: begin
            if (correct_d) begin
              run_q <= run_inc_d;
              if (run_inc_d >= LOCK_LEN_C) state_q <= LOCKED;
            end else begin
              run_q <= 4'd0;
            end
          end
          LOCKED: begin
            if (!correct_d) state_q <= LOST;
          end
          LOST: begin
            if (correct_d) begin
              state_q <= TRACK;
              run_q   <= 4'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (err_inc_d),
    .cnt_o (err_cnt)
  );

  assign phase     = phase_q;
  assign wrap      = wrap_q;
  assign seq_err   = seq_err_q;
  assign locked    = (state_q == LOCKED);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Bench for count_sequence_checker: three instances (defaults, ERR_W=2,
// LOCK_LEN=1). A reference model pushes the expected output vector of every
// instance when inputs are driven; it is popped and compared after the edge.
// Directed checks add explicit constants at the interesting points.
module tb_count_sequence_checker;

  localparam int W = 17;  // {state, phase, wrap, locked, seq_err, err_cnt[7:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst_v   = '0;
  logic [2:0]      valid_v = '0;
  logic [2:0][1:0] cnt_v   = '0;

  logic [2:0][3:0] phase_w;
  logic [2:0]      wrap_w, locked_w, serr_w;
  logic [2:0][1:0] state_w;
  logic [7:0]      err0, err2;
  logic [1:0]      err1;

  count_sequence_checker u_dut0 (
    .clk(clk), .rst(rst_v[0]), .count(cnt_v[0]), .count_valid(valid_v[0]),
    .phase(phase_w[0]), .wrap(wrap_w[0]), .locked(locked_w[0]),
    .seq_err(serr_w[0]), .err_cnt(err0), .state_dbg(state_w[0]));

  count_sequence_checker #(.ERR_W(2)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .count(cnt_v[1]), .count_valid(valid_v[1]),
    .phase(phase_w[1]), .wrap(wrap_w[1]), .locked(locked_w[1]),
    .seq_err(serr_w[1]), .err_cnt(err1), .state_dbg(state_w[1]));

  count_sequence_checker #(.LOCK_LEN(1)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .count(cnt_v[2]), .count_valid(valid_v[2]),
    .phase(phase_w[2]), .wrap(wrap_w[2]), .locked(locked_w[2]),
    .seq_err(serr_w[2]), .err_cnt(err2), .state_dbg(state_w[2]));

  // Clock/reset and scoreboard state
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  int lock_len[3] = '{4, 4, 1};
  int err_max[3]  = '{255, 3, 255};
  int m_state[3], m_prev[3], m_run[3], m_err[3];
  logic [3:0] m_phase[3];
  bit m_wrap[3], m_serr[3];

  function automatic logic [W-1:0] observed(input int j);
    logic [7:0] e;
    e = (j == 0) ? err0 : (j == 1) ? {6'b0, err1} : err2;
    return {state_w[j], phase_w[j], wrap_w[j], locked_w[j], serr_w[j], e};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: expected outputs after the coming edge.
  task automatic model(input int j);
    logic [1:0] c;
    bit ok;
    c = cnt_v[j];
    if (rst_v[j]) begin
      m_state[j] = 0; m_prev[j] = 0; m_run[j] = 0; m_err[j] = 0;
      m_phase[j] = 4'b0000; m_wrap[j] = 0; m_serr[j] = 0;
    end else begin
      m_wrap[j] = 0;
      m_serr[j] = 0;
      if (valid_v[j]) begin
        ok = (int'(c) == (m_prev[j] + 1) % 4);
        if (m_state[j] == 0) begin
          m_state[j] = 1;
          m_run[j]   = 0;
        end else begin
          if (!ok) begin
            m_serr[j] = 1;
            if (m_err[j] < err_max[j]) m_err[j]++;
          end else if (m_prev[j] == 3) begin
            m_wrap[j] = 1;
          end
          case (m_state[j])
            1: if (ok) begin
                 m_run[j]++;
                 if (m_run[j] >= lock_len[j]) m_state[j] = 2;
               end else m_run[j] = 0;
            2: if (!ok) m_state[j] = 3;
            3: if (ok) begin m_state[j] = 1; m_run[j] = 1; end
            default: ;
          endcase
        end
        m_prev[j]  = int'(c);
        m_phase[j] = 4'b0001 << c;
      end
    end
    exp_q.push_back({2'(m_state[j]), m_phase[j], 1'(m_wrap[j]), 1'(m_state[j] == 2),
                     1'(m_serr[j]), 8'(m_err[j])});
  endtask

  // Driver: push expectations for current inputs, clock once, compare.
  task automatic tick();
    logic [W-1:0] e;
    for (int j = 0; j < 3; j++) model(j);
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("sb%0d_empty", j), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("sb%0d", j), 32'(observed(j)), 32'(e));
      end
    end
  endtask

  task automatic step(input int k, input bit v, input logic [1:0] c, input bit r);
    rst_v    = '0;
    valid_v  = '0;
    cnt_v[k] = c;
    valid_v[k] = v;
    rst_v[k]   = r;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [1:0] s29[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] s30[8] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset all instances
    rst_v = '1; valid_v = '0;
    tick();
    tick();
    check("reset_vec0", 32'(observed(0)), 32'd0);
    check("reset_vec1", 32'(observed(1)), 32'd0);

    // Lock on a clean stream; locked one cycle after the 5th sample
    for (int i = 0; i < 6; i++) begin
      step(0, 1, s29[i], 0);
      if (i == 3) check("lock_not_yet", 32'(locked_w[0]), 32'd0);
      if (i == 4) begin
        check("lock_rise", 32'(locked_w[0]), 32'd1);
        check("wrap_30", 32'(wrap_w[0]), 32'd1);
      end
      if (i == 5) check("wrap_once", 32'(wrap_w[0]), 32'd0);
    end
    check("err_clean", 32'(err0), 32'd0);

    // Inject a skip while locked, then re-synchronise and relock
    step(0, 1, 2'd2, 0);
    step(0, 1, 2'd3, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, s30[i], 0);
      if (i == 2) begin
        check("skip_err", 32'(serr_w[0]), 32'd1);
        check("skip_unlock", 32'(locked_w[0]), 32'd0);
      end
      if (i == 3) begin
        check("lost_to_track", 32'(state_w[0]), 32'd1);
        check("resync_wrap", 32'(wrap_w[0]), 32'd1);
      end
      if (i == 6) check("relock", 32'(locked_w[0]), 32'd1);
    end
    check("err_one", 32'(err0), 32'd1);

    // Gap in count_valid holds phase and raises no error
    step(0, 0, 2'd0, 1);
    step(0, 1, 2'd2, 0);
    step(0, 1, 2'd3, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 2'($urandom_range(0, 3)), 0);
      check("gap_phase", 32'(phase_w[0]), 32'h8);
      check("gap_noerr", 32'(serr_w[0]), 32'd0);
    end
    step(0, 1, 2'd0, 0);
    check("gap_wrap", 32'(wrap_w[0]), 32'd1);
    check("gap_wrap_noerr", 32'(serr_w[0]), 32'd0);

    // Reset while locked discards history
    step(0, 1, 2'd1, 0);
    step(0, 1, 2'd2, 0);
    step(0, 1, 2'd3, 0);
    check("pre_rst_lock", 32'(locked_w[0]), 32'd1);
    step(0, 1, 2'd1, 1);
    check("mid_rst_vec", 32'(observed(0)), 32'd0);
    step(0, 1, 2'd2, 0);
    check("first_after_rst", 32'(serr_w[0]), 32'd0);
    check("first_after_rst_st", 32'(state_w[0]), 32'd1);

    // ERR_W=2: constant count saturates the error counter
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 2'd1, 0);
      if (serr_w[1]) pulses++;
    end
    check("sat_pulses", 32'(pulses), 32'd7);
    check("sat_value", 32'(err1), 32'd3);
    step(1, 1, 2'd1, 0);
    check("sat_hold", 32'(err1), 32'd3);
    check("sat_still_pulses", 32'(serr_w[1]), 32'd1);

    // LOCK_LEN=1: lock and wrap together
    step(2, 1, 2'd3, 0);
    step(2, 1, 2'd0, 0);
    check("ll1_locked", 32'(locked_w[2]), 32'd1);
    check("ll1_wrap", 32'(wrap_w[2]), 32'd1);

    step(0, 0, 2'd0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_sequence_checker.md
COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

Interface
REQ-001 Parameter LOCK_LEN, default 4: consecutive correct increments required to declare lock (legal range 1..15).
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 count  input  2  free-running 2-bit count value (0,1,2,3,0,...) from the upstream counter.
REQ-006 count_valid  input  1  high when count is a new sample to check; count is ignored when low.
REQ-007 phase  output  4  one-hot decode of the last accepted count (bit n set when count==n).
REQ-008 wrap  output  1  one-cycle pulse when an accepted transition is 3->0.
REQ-009 locked  output  1  high while the FSM is in LOCKED.
REQ-010 seq_err  output  1  one-cycle pulse on an accepted sample that is not previous+1 mod 4, once a previous sample exists.
REQ-011 err_cnt  output  ERR_W  count of seq_err pulses since reset; saturates at all-ones.

Function
REQ-012 All outputs are registered; each output reflects the sample accepted on the previous rising edge (latency 1 cycle).
REQ-013 Accepted sample: count_valid==1 at a rising edge with rst==0.
REQ-014 Expected value = (previous accepted count + 1) mod 4; 3->0 wrap-around is correct, never an error.
REQ-015 FSM states: IDLE, TRACK, LOCKED, LOST; IDLE on reset.
REQ-016 IDLE: first accepted sample stores count, no error is checked, next state TRACK with run counter = 0.
REQ-017 TRACK: correct sample increments run counter; when run counter reaches LOCK_LEN, go to LOCKED; wrong sample clears run counter to 0, pulses seq_err, stays TRACK.
REQ-018 LOCKED: correct samples hold LOCKED; wrong sample pulses seq_err, next state LOST.
REQ-019 LOST: correct sample goes to TRACK with run counter = 1; wrong sample pulses seq_err, stays LOST.
REQ-020 Every accepted sample (correct or wrong) becomes the new previous value, so re-synchronisation uses the latest count.
REQ-021 count_valid low: FSM, previous value, run counter, phase and err_cnt hold; wrap and seq_err are 0.
REQ-022 Repeated value (count == previous) counts as wrong.
REQ-023 err_cnt at all-ones stays all-ones on further errors; seq_err still pulses.
REQ-024 wrap and seq_err are mutually exclusive (wrap requires a correct 3->0 transition).

Reset
REQ-025 rst high at a rising edge: state IDLE, run counter 0, previous value 0, phase 4'b0000, wrap 0, locked 0, seq_err 0, err_cnt 0.
REQ-026 rst takes priority over count_valid; a reset in mid-operation (including during LOCKED) discards all history, and the next accepted sample is treated as the first.

Structure
REQ-027 Shared package holds the FSM state encoding (2-bit: IDLE=0, TRACK=1, LOCKED=2, LOST=3) and the default LOCK_LEN and ERR_W constants.
REQ-028 A sub-module sat_counter (parameter width, synchronous reset, increment enable, saturate at all-ones) implements err_cnt; the rest is flat.

Verification
REQ-029 Reset, then valid stream 0,1,2,3,0,1 each cycle -> locked rises 1 cycle after the 5th sample (4th correct increment), wrap pulses once (for 3->0), err_cnt=0.
REQ-030 Locked on stream, inject 0,1,3,0,1,2,3,0 -> seq_err pulses for 1->3 only, locked drops, LOST->TRACK on 3->0, relock after 4 further correct increments, err_cnt=1.
REQ-031 Valid stream 2,3 then count_valid low 5 cycles with count toggling randomly, then 0 -> no seq_err, phase holds 4'b1000 during the gap, wrap pulses on 0.
REQ-032 Locked, assert rst for 1 cycle with count_valid high -> all outputs at reset values next cycle; next sample 2 produces no error.
REQ-033 ERR_W=2, feed constant count=1 for 8 accepted samples -> seq_err pulses 7 times, err_cnt reaches 3 and holds.
REQ-034 LOCK_LEN=1, stream 3,0 -> locked high and wrap pulse both appear 1 cycle after the sample 0.
